irda_rx_deframer: RTL
=====================

// Module: irda_rx_deframer
// PURPOSE
//  IrDA SIR receive path, the receiving end of the TXD pulse-encoded link.
//  Samples the photodiode pulse line, turns RZI pulses back into NRZ bits and
//  deframes start + DATA_BITS (LSB first) + stop. Delivers each byte with a
//  one-cycle valid strobe. Sits between the IR front-end and the RX byte consumer.
// PARAMETERS
//  DATA_BITS   8   data bits per frame
//  OVERSAMPLE  16  baud16_tick pulses per bit period; must be even, >=8
// PORTS
//  clk          in   1          system clock, all logic on rising edge
//  rst_n        in   1          asynchronous, active-low reset
//  baud16_tick  in   1          1-clk enable at OVERSAMPLE x bit rate
//  irda_in      in   1          raw IR pulse line; high = light pulse (asynchronous)
//  rx_data      out  DATA_BITS  last good byte, held until next good frame
//  rx_valid     out  1          1-clk strobe: rx_data updated
//  frame_err    out  1          1-clk strobe: pulse seen in stop window
//  busy         out  1          high from start detect until return to IDLE
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, counters/shift reg 0; async assert,
//   synchronous deassert assumed upstream. Reset mid-frame aborts; no strobes.
//  Input: 2-FF synchroniser on irda_in, then rising-edge detect (edge = sync
//   high & prev low), evaluated every clk, not gated by baud16_tick.
//   Pulse = logical 0; no pulse in a bit window = logical 1.
//  FSM IDLE -> START -> DATA -> STOP -> IDLE:
//   IDLE : on edge -> START, tick_cnt=0, busy=1.
//   START: count baud16_tick; at OVERSAMPLE/2 ticks -> DATA, bit_cnt=0,
//     tick_cnt=0, pulse_seen=0 (window now centred on next expected pulse).
//   DATA : window = OVERSAMPLE ticks. Any edge in window sets pulse_seen.
//     On tick ending window (tick_cnt==OVERSAMPLE-1): shift in ~pulse_seen
//     at MSB (LSB-first receive), clear pulse_seen, bit_cnt++.
//     After DATA_BITS windows -> STOP.
//   STOP : one more window. At its end: no pulse -> rx_data<=shift,
//     rx_valid=1; pulse -> frame_err=1, rx_data unchanged. Then -> IDLE, busy=0.
//  Timing: strobe asserted the clk after the tick ending the stop window;
//   never both strobes in one cycle; busy drops in the same cycle as the strobe.
//  Edge arriving in the same clk as a window-ending tick counts toward the
//   window that is ending, not the next one.
//  Edges during START are ignored (start pulse's own tail/bounce).
//  Multiple edges in one window = a single 0 bit.
//  Back-to-back frames: new edge in the IDLE cycle right after STOP is accepted.
//  Counters: tick_cnt $clog2(OVERSAMPLE) bits, bit_cnt $clog2(DATA_BITS+1) bits;
//   no wrap beyond terminal values; tick_cnt only advances on baud16_tick.
//  Without baud16_tick the FSM holds its state indefinitely (no timeout).
// TESTING
//  1 Reset: rst_n=0 mid-DATA -> rx_data=0, rx_valid=0, busy=0 immediately, FSM IDLE.
//  2 Byte 0xA5 sent, 3/16 pulses, clk=16*tick -> rx_data=0xA5, one rx_valid,
//    frame_err=0, strobe 8+9*16=152 ticks after start edge (+sync latency).
//  3 0x00 then 0xFF back-to-back, no idle gap -> two rx_valid, data 0x00, 0xFF.
//  4 Pulse injected in stop window after 0x3C -> frame_err=1, rx_valid=0,
//    rx_data keeps previous good value.
//  5 Edge coincident with window-ending tick of bit 2 of 0xFF -> bit 2 reads 0,
//    rx_data=0xFB; bit 3 unaffected.
//  6 Double pulse in one window and a glitch during START -> decoded byte
//    matches the pulse-per-window interpretation, no extra bits.

Source files
------------

// File: rtl/irda_rx_if.sv
// Byte-delivery side of the IrDA SIR receiver: decoded data plus status strobes.
interface irda_rx_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 frame_err;
  logic                 busy;

  modport master (output rx_data, rx_valid, frame_err, busy);
  modport slave  (input  rx_data, rx_valid, frame_err, busy);
endinterface

// File: rtl/irda_rx_deframer.sv
// IrDA SIR receiver: synchronises the pulse line, decodes RZI pulses to NRZ bits
// and deframes start + DATA_BITS (LSB first) + stop into a byte with status strobes.
module irda_rx_deframer #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      baud16_tick,
  input  logic      irda_in,
  irda_rx_if.master rx
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] HALF_M1  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] WIN_END  = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  state_e               state_q, state_d;
  logic                 sync1_q, sync2_q, prev_q;
  logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic                 pulse_seen_q, pulse_seen_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 frame_err_q, frame_err_d;

  logic pulse_edge, win_end, start_done, pulse_w;

  assign pulse_edge = sync2_q & ~prev_q;
  assign win_end    = baud16_tick & (tick_cnt_q == WIN_END);
  assign start_done = baud16_tick & (tick_cnt_q == HALF_M1);
  // An edge landing on the window-closing tick still belongs to the closing window.
  assign pulse_w    = pulse_seen_q | pulse_edge;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      prev_q       <= 1'b0;
      tick_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      pulse_seen_q <= 1'b0;
      shift_q      <= '0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync1_q      <= irda_in;
      sync2_q      <= sync1_q;
      prev_q       <= sync2_q;
      tick_cnt_q   <= tick_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      pulse_seen_q <= pulse_seen_d;
      shift_q      <= shift_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (pulse_edge) state_d = S_START;
      S_START: if (start_done) state_d = S_DATA;
      S_DATA:  if (win_end && bit_cnt_q == BIT_LAST) state_d = S_STOP;
      S_STOP:  if (win_end) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    tick_cnt_d   = tick_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    pulse_seen_d = pulse_seen_q;
    shift_d      = shift_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = 1'b0;
    frame_err_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pulse_edge) begin
          tick_cnt_d   = '0;
          bit_cnt_d    = '0;
          pulse_seen_d = 1'b0;
        end
      end
      // Half a bit of ticks re-centres the windows on the expected pulse positions;
      // edges here are the start pulse's tail and are deliberately dropped.
      S_START: begin
        if (baud16_tick) begin
          if (tick_cnt_q == HALF_M1) begin
            tick_cnt_d   = '0;
            bit_cnt_d    = '0;
            pulse_seen_d = 1'b0;
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end
      end
      S_DATA: begin
        pulse_seen_d = pulse_w;
        if (baud16_tick) begin
          if (tick_cnt_q == WIN_END) begin
            tick_cnt_d   = '0;
            pulse_seen_d = 1'b0;
            shift_d      = {~pulse_w, shift_q[DATA_BITS-1:1]};
            bit_cnt_d    = bit_cnt_q + BW'(1);
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end
      end
      S_STOP: begin
        pulse_seen_d = pulse_w;
        if (baud16_tick) begin
          if (tick_cnt_q == WIN_END) begin
            tick_cnt_d   = '0;
            pulse_seen_d = 1'b0;
            if (pulse_w) begin
              frame_err_d = 1'b1;
            end else begin
              rx_valid_d = 1'b1;
              rx_data_d  = shift_q;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end
      end
      default: ;
    endcase
  end

  assign rx.rx_data   = rx_data_q;
  assign rx.rx_valid  = rx_valid_q;
  assign rx.frame_err = frame_err_q;
  assign rx.busy      = (state_q != S_IDLE);

endmodule
